// File: rtl/pipe_reg.sv
// pipe_reg: DEPTH-stage valid/ready pipeline register with bubble collapse and synchronous flush.
// Define PIPE_REG_OCC_EN to add the registered occupancy count output.
module pipe_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush
`ifdef PIPE_REG_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_nxt;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] d_nxt [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic             xfer_in;
    logic             xfer_out;

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign xfer_out  = out_valid & out_ready;
    assign in_ready  = adv[0] & ~flush & reset;
    assign xfer_in   = in_valid & in_ready;

    // A stage advances unless it and every stage downstream is full and the output stalls.
    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
        assign adv[g] = ~(&v[DEPTH-1:g]) | xfer_out;

        if (g == 0) begin : g_head
            assign src_v[g] = xfer_in;
            assign src_d[g] = in_data;
        end else begin : g_body
            assign src_v[g] = v[g-1];
            assign src_d[g] = d[g-1];
        end

        // Data only moves with a valid word so an emptied stage keeps its last value.
        assign v_nxt[g] = flush ? 1'b0 : (adv[g] ? src_v[g] : v[g]);
        assign d_nxt[g] = (adv[g] & src_v[g] & ~flush) ? src_d[g] : d[g];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= '0;
            d <= '{default: '0};
        end else begin
            v <= v_nxt;
            d <= d_nxt;
        end
    end

`ifdef PIPE_REG_OCC_EN
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ_q;

    // Running count of valid stages; flush wins over any concurrent transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else if (xfer_in && !xfer_out) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (!xfer_in && xfer_out) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    assign occupancy = occ_q;
`else
    // Occupancy tracking not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: table, directed and random checks of pipe_reg (DEPTH=3 and DEPTH=1 instances)
// against a queue-based reference model.
module tb_pipe_reg;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         a_iv, a_ordy, a_fl, a_ir, a_ov;
    logic [W-1:0] a_din, a_od;
    logic         b_iv, b_ordy, b_fl, b_ir, b_ov;
    logic [W-1:0] b_din, b_od;
`ifdef PIPE_REG_OCC_EN
    logic [1:0]   a_occ;
    logic [0:0]   b_occ;
`endif

    pipe_reg #(.WIDTH(W), .DEPTH(3)) u_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_iv),
        .in_data   (a_din),
        .in_ready  (a_ir),
        .out_valid (a_ov),
        .out_data  (a_od),
        .out_ready (a_ordy),
        .flush     (a_fl)
`ifdef PIPE_REG_OCC_EN
        ,
        .occupancy (a_occ)
`endif
    );

    pipe_reg #(.WIDTH(W), .DEPTH(1)) u_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_iv),
        .in_data   (b_din),
        .in_ready  (b_ir),
        .out_valid (b_ov),
        .out_data  (b_od),
        .out_ready (b_ordy),
        .flush     (b_fl)
`ifdef PIPE_REG_OCC_EN
        ,
        .occupancy (b_occ)
`endif
    );

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int bk = 0;

    // Reference model: per instance, a FIFO of words with their entry cycle.
    logic [W-1:0] mq_d [2][$];
    int           mq_t [2][$];
    int           last_leave [2];
    logic [W-1:0] last_out [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // A word is at the output once DEPTH cycles passed since entry and its predecessor has left.
    task automatic model(input int id, input int dep, input logic iv, input logic [W-1:0] din,
                         input logic ordy, input logic fl, input logic ir, input logic ov,
                         input logic [W-1:0] od);
        logic  e_ir;
        logic  e_ov;
        string tag;
        tag = (id == 0) ? "d3" : "d1";
        if (!reset) begin
            mq_d[id].delete();
            mq_t[id].delete();
            last_leave[id] = -1000;
            last_out[id]   = '0;
            e_ir = 1'b0;
            e_ov = 1'b0;
        end else begin
            e_ov = (mq_d[id].size() > 0) && (cyc >= mq_t[id][0] + dep) && (cyc > last_leave[id]);
            if (e_ov) last_out[id] = mq_d[id][0];
            e_ir = !fl && ((mq_d[id].size() < dep) || ordy);
        end
        chk({tag, " model in_ready"}, 32'(ir), 32'(e_ir));
        chk({tag, " model out_valid"}, 32'(ov), 32'(e_ov));
        chk({tag, " model out_data"}, 32'(od), 32'(last_out[id]));
`ifdef PIPE_REG_OCC_EN
        chk({tag, " model occupancy"}, (id == 0) ? 32'(a_occ) : 32'(b_occ), 32'(mq_d[id].size()));
`endif
        if (reset) begin
            if (e_ov && ordy) begin
                void'(mq_d[id].pop_front());
                void'(mq_t[id].pop_front());
                last_leave[id] = cyc;
            end
            if (fl) begin
                mq_d[id].delete();
                mq_t[id].delete();
            end else if (iv && e_ir) begin
                mq_d[id].push_back(din);
                mq_t[id].push_back(cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        model(0, 3, a_iv, a_din, a_ordy, a_fl, a_ir, a_ov, a_od);
        model(1, 1, b_iv, b_din, b_ordy, b_fl, b_ir, b_ov, b_od);
        cyc++;
    end

    task automatic drv(input logic iv, input logic [W-1:0] din, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        a_iv   = iv;
        a_din  = din;
        a_ordy = ordy;
        a_fl   = fl;
    endtask

    // DEPTH=1 instance: continuous input with alternating out_ready, then random traffic.
    initial begin
        b_iv = 1'b0; b_din = '0; b_ordy = 1'b0; b_fl = 1'b0;
        @(posedge reset);
        forever begin
            @(posedge clk);
            #1;
            if (bk < 60) begin
                b_iv   = 1'b1;
                b_din  = W'(bk + 1);
                b_ordy = bk[0];
                b_fl   = 1'b0;
            end else begin
                b_iv   = ($urandom_range(3) != 0);
                b_din  = W'($urandom);
                b_ordy = ($urandom_range(2) != 0);
                b_fl   = ($urandom_range(15) == 0);
            end
            bk++;
        end
    end

    typedef struct {
        logic         iv;
        logic [W-1:0] din;
        logic         ordy;
        logic         e_ir;
        logic         e_ov;
        logic [W-1:0] e_od;
    } vec_t;

    vec_t tbl [19];

    initial begin
        // Streaming 0x01..0x05, then backpressure with 0xA0..0xA3.
        tbl[0]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h01};
        tbl[4]  = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h02};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h05};
        tbl[9]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h05};
        tbl[10] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h05};
        tbl[11] = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h05};
        tbl[12] = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA0};
        tbl[13] = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA0};
        tbl[14] = '{1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA0};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA1};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA3};

        reset = 1'b0;
        a_iv = 1'b0; a_din = '0; a_ordy = 1'b0; a_fl = 1'b0;
        @(negedge clk);
        chk("reset out_valid", 32'(a_ov), 32'(0));
        chk("reset out_data", 32'(a_od), 32'(0));
        chk("reset in_ready", 32'(a_ir), 32'(0));
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("release in_ready", 32'(a_ir), 32'(1));

        for (int i = 0; i < 19; i++) begin
            drv(tbl[i].iv, tbl[i].din, tbl[i].ordy, 1'b0);
            @(negedge clk);
            chk($sformatf("tbl[%0d] in_ready", i), 32'(a_ir), 32'(tbl[i].e_ir));
            chk($sformatf("tbl[%0d] out_valid", i), 32'(a_ov), 32'(tbl[i].e_ov));
            chk($sformatf("tbl[%0d] out_data", i), 32'(a_od), 32'(tbl[i].e_od));
        end

        // Full pipe streaming: one in and one out per cycle.
        for (int k = 0; k < 3; k++) drv(1'b1, W'(8'hB0 + k), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, W'(8'hB3 + k), 1'b1, 1'b0);
            @(negedge clk);
            chk("full in_ready", 32'(a_ir), 32'(1));
            chk("full out_valid", 32'(a_ov), 32'(1));
            chk("full out_data", 32'(a_od), 32'(8'hB0 + k));
`ifdef PIPE_REG_OCC_EN
            chk("full occupancy", 32'(a_occ), 32'(3));
`endif
        end
        repeat (4) drv(1'b0, '0, 1'b1, 1'b0);

        // Flush with two words in flight overrides a concurrent input.
        drv(1'b1, 8'hC0, 1'b1, 1'b0);
        drv(1'b1, 8'hC1, 1'b1, 1'b0);
        drv(1'b1, 8'h55, 1'b1, 1'b1);
        @(negedge clk);
        chk("flush in_ready", 32'(a_ir), 32'(0));
        for (int k = 0; k < 5; k++) begin
            drv(1'b0, '0, 1'b1, 1'b0);
            @(negedge clk);
            chk("post-flush out_valid", 32'(a_ov), 32'(0));
            chk("post-flush out_data", 32'(a_od == 8'h55), 32'(0));
`ifdef PIPE_REG_OCC_EN
            chk("post-flush occupancy", 32'(a_occ), 32'(0));
`endif
        end

        // Asynchronous reset mid-operation.
        drv(1'b1, 8'hD0, 1'b0, 1'b0);
        drv(1'b1, 8'hD1, 1'b0, 1'b0);
        drv(1'b0, '0, 1'b0, 1'b0);
        drv(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre-reset out_valid", 32'(a_ov), 32'(1));
        chk("pre-reset out_data", 32'(a_od), 32'(8'hD0));
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async reset out_valid", 32'(a_ov), 32'(0));
        chk("async reset out_data", 32'(a_od), 32'(0));
        chk("async reset in_ready", 32'(a_ir), 32'(0));
        @(posedge clk);
        #3 reset = 1'b1;
        drv(1'b1, 8'h7E, 1'b1, 1'b0);
        @(negedge clk);
        chk("after reset in_ready", 32'(a_ir), 32'(1));
        for (int k = 1; k <= 3; k++) begin
            drv(1'b0, '0, 1'b1, 1'b0);
            @(negedge clk);
            chk($sformatf("after reset out_valid +%0d", k), 32'(a_ov), 32'(k == 3));
        end
        chk("after reset out_data", 32'(a_od), 32'(8'h7E));

        // Random traffic checked by the reference model.
        for (int k = 0; k < 3000; k++) begin
            drv(($urandom_range(3) != 0), W'($urandom), ($urandom_range(2) != 0),
                ($urandom_range(15) == 0));
        end
        repeat (10) drv(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
